// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the Y86-64 pipeline stages.
//   stat_t      - architectural status codes carried down the pipe
//   ICODE_NOP   - instruction code loaded into a bubbled stage
//   rnone()     - "no register" id (all ones) for a given register-id width
//   wb_state_t  - writeback-stage run/halt state
package y86_pkg;

   typedef enum logic [1:0] {
      STAT_AOK = 2'b00,
      STAT_HLT = 2'b01,
      STAT_ADR = 2'b10,
      STAT_INS = 2'b11
   } stat_t;

   localparam int ICODE_NOP = 1;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } wb_state_t;

   // All-ones register id of width reg_w (RNONE).
   function automatic int unsigned rnone(input int reg_w);
      return (32'd1 << reg_w) - 32'd1;
   endfunction

endpackage

// File: rtl/wb_stage_reg_if.sv
// wb_stage_reg_if: memory-to-writeback boundary of the pipeline.
//   master : drives M-stage results and stall/bubble controls, observes W.
//   slave  : the writeback stage register (wb_stage_reg).
// Signals:
//   w_stall, w_bubble            pipeline control from hazard unit
//   m_stat/icode/valE/valM/dstE/dstM  memory-stage results
//   W_*                          registered writeback contents
//   W_valid                      W holds a real instruction
//   wbE_en, wbM_en               register-file write enables
//   halted, exc_stat             sticky stop indication and its cause
//   retired_cnt                  count of AOK instructions retired
interface wb_stage_reg_if #(
   parameter int DATA_W  = 64,
   parameter int REG_W   = 4,
   parameter int ICODE_W = 4,
   parameter int CNT_W   = 32
);
   logic               w_stall;
   logic               w_bubble;
   logic [1:0]         m_stat;
   logic [ICODE_W-1:0] m_icode;
   logic [DATA_W-1:0]  m_valE;
   logic [DATA_W-1:0]  m_valM;
   logic [REG_W-1:0]   m_dstE;
   logic [REG_W-1:0]   m_dstM;

   logic [1:0]         W_stat;
   logic [ICODE_W-1:0] W_icode;
   logic [DATA_W-1:0]  W_valE;
   logic [DATA_W-1:0]  W_valM;
   logic [REG_W-1:0]   W_dstE;
   logic [REG_W-1:0]   W_dstM;
   logic               W_valid;
   logic               wbE_en;
   logic               wbM_en;
   logic               halted;
   logic [1:0]         exc_stat;
   logic [CNT_W-1:0]   retired_cnt;

   modport master (
      output w_stall, w_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
      input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, W_valid,
             wbE_en, wbM_en, halted, exc_stat, retired_cnt
   );

   modport slave (
      input  w_stall, w_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
      output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, W_valid,
             wbE_en, wbM_en, halted, exc_stat, retired_cnt
   );
endinterface

// File: rtl/pipe_reg_bub.sv
// pipe_reg_bub: pipeline register with hold and load-bubble controls.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (resets q to BUB)
//   hold        keep current contents (wins over bubble)
//   bubble      load the BUB constant instead of d
//   d, q        WIDTH-bit payload in/out
module pipe_reg_bub #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] BUB   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             bubble,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= BUB;
      end else if (hold) begin
         q <= q;
      end else if (bubble) begin
         q <= BUB;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: Y86-64 writeback pipeline register.
// Captures memory-stage results each cycle (with stall / bubble), decodes the
// register-file write enables, freezes on the first non-AOK instruction that
// reaches W and reports its status, and counts AOK instructions retired.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         wb_stage_reg_if.slave (M inputs, controls, W outputs, status)
module wb_stage_reg
   import y86_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int REG_W   = 4,
   parameter int ICODE_W = 4,
   parameter int CNT_W   = 32
) (
   input logic            clk,
   input logic            rst_n,
   wb_stage_reg_if.slave  bus
);

   localparam logic [REG_W-1:0] RNONE = REG_W'(rnone(REG_W));

   typedef struct packed {
      logic               valid;
      logic [1:0]         stat;
      logic [ICODE_W-1:0] icode;
      logic [DATA_W-1:0]  valE;
      logic [DATA_W-1:0]  valM;
      logic [REG_W-1:0]   dstE;
      logic [REG_W-1:0]   dstM;
   } w_pay_t;

   localparam w_pay_t BUBBLE = w_pay_t'({1'b0, STAT_AOK, ICODE_W'(ICODE_NOP),
                                         {(2*DATA_W){1'b0}}, RNONE, RNONE});

   wb_state_t        state;
   logic [1:0]       exc_q;
   logic [CNT_W-1:0] retired_q;
   w_pay_t           m_pay;
   w_pay_t           w_pay;
   logic             halt_cond;
   logic             w_aok;
   logic             w_hold;

   assign m_pay = '{valid: 1'b1, stat: bus.m_stat, icode: bus.m_icode,
                    valE: bus.m_valE, valM: bus.m_valM,
                    dstE: bus.m_dstE, dstM: bus.m_dstM};

   assign w_aok     = w_pay.valid && (w_pay.stat == STAT_AOK);
   assign halt_cond = (state == RUN) && w_pay.valid && (w_pay.stat != STAT_AOK);
   // Once halting (or halted) W freezes, overriding both stall and bubble.
   assign w_hold    = (state == HALTED) || halt_cond || bus.w_stall;

   pipe_reg_bub #(
      .WIDTH ($bits(w_pay_t)),
      .BUB   (BUBBLE)
   ) u_wreg (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (w_hold),
      .bubble (bus.w_bubble),
      .d      (m_pay),
      .q      (w_pay)
   );

   // Halt FSM and retire counter. An instruction retires when it leaves W
   // (W replaced, not held) while running with AOK status.
   // NOTE: every register here, counter included, gets an explicit value in
   // the asynchronous reset branch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         exc_q     <= STAT_AOK;
         retired_q <= '0;
      end else if (state == RUN) begin
         if (halt_cond) begin
            state <= HALTED;
            exc_q <= w_pay.stat;
         end else if (!bus.w_stall && w_aok) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   assign bus.W_stat      = w_pay.stat;
   assign bus.W_icode     = w_pay.icode;
   assign bus.W_valE      = w_pay.valE;
   assign bus.W_valM      = w_pay.valM;
   assign bus.W_dstE      = w_pay.dstE;
   assign bus.W_dstM      = w_pay.dstM;
   assign bus.W_valid     = w_pay.valid;
   assign bus.wbE_en      = (state == RUN) && w_aok && (w_pay.dstE != RNONE);
   assign bus.wbM_en      = (state == RUN) && w_aok && (w_pay.dstM != RNONE);
   assign bus.halted      = (state == HALTED);
   assign bus.exc_stat    = exc_q;
   assign bus.retired_cnt = retired_q;

endmodule
